// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake; iterative unsigned multiply/divide into HI/LO.
// Optional signed MULT/DIV on ops 10/11 when SEQ_ALU_SIGNED_MD_EN is defined.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_MULTU = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
`ifdef SEQ_ALU_SIGNED_MD_EN
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd11;
`endif

    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] neg_fn(input logic [WIDTH-1:0] v);
        return (~v) + ONE_W;
    endfunction

`ifdef SEQ_ALU_SIGNED_MD_EN
    function automatic logic [WIDTH-1:0] mag_fn(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_fn(v) : v;
    endfunction
`endif

    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] f_op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (f_op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            default: r = ZERO_W;
        endcase
        return r;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] b_r;
    logic             is_div_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic [WIDTH-1:0]   alu_s;
    logic               md_s;
    logic               div_s;
    logic [WIDTH-1:0]   opa_s;
    logic [WIDTH-1:0]   opb_s;
    logic               neg_q_s;
    logic               neg_r_s;
    logic [WIDTH:0]     shifted_s;
    logic               ge_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH-1:0]   step_hi_s;
    logic [WIDTH-1:0]   step_lo_s;
    logic [2*WIDTH-1:0] prod_neg_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic [WIDTH-1:0]   fin_lo_s;

    assign alu_s = alu_fn(op, src_a, src_b);

    // Decode a multi-cycle request and prepare the operands the engine latches.
    always_comb begin
        md_s    = (op == OP_MULTU) || (op == OP_DIVU);
        div_s   = (op == OP_DIVU);
        opa_s   = src_a;
        opb_s   = src_b;
        neg_q_s = 1'b0;
        neg_r_s = 1'b0;
`ifdef SEQ_ALU_SIGNED_MD_EN
        // A zero divisor keeps the all-ones quotient unnegated so lo stays all ones.
        if ((op == OP_MULT) || (op == OP_DIV)) begin
            md_s    = 1'b1;
            div_s   = (op == OP_DIV);
            opa_s   = mag_fn(src_a);
            opb_s   = mag_fn(src_b);
            neg_q_s = (src_a[WIDTH-1] ^ src_b[WIDTH-1]) & (~div_s | (src_b != ZERO_W));
            neg_r_s = div_s & src_a[WIDTH-1];
        end else begin
            neg_q_s = 1'b0;
        end
`endif
    end

    // One engine iteration: shift-add multiply or restoring divide on the accumulator pair.
    always_comb begin
        shifted_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, b_r});
        diff_s    = shifted_s[WIDTH-1:0] - b_r;
        mul_sum_s = acc_lo_r[0] ? ({1'b0, acc_hi_r} + {1'b0, b_r}) : {1'b0, acc_hi_r};
        if (is_div_r) begin
            if (ge_s) begin
                step_hi_s = diff_s;
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = shifted_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction folded into the completing write.
    always_comb begin
        prod_neg_s = (~{step_hi_s, step_lo_s}) + ONE_2W;
        fin_hi_s   = step_hi_s;
        fin_lo_s   = step_lo_s;
        if (is_div_r) begin
            if (neg_q_r) begin
                fin_lo_s = neg_fn(step_lo_s);
            end else begin
                fin_lo_s = step_lo_s;
            end
            if (neg_r_r) begin
                fin_hi_s = neg_fn(step_hi_s);
            end else begin
                fin_hi_s = step_hi_s;
            end
        end else if (neg_q_r) begin
            {fin_hi_s, fin_lo_s} = prod_neg_s;
        end else begin
            {fin_hi_s, fin_lo_s} = {step_hi_s, step_lo_s};
        end
    end

    // Control FSM with registered handshake, result and HI/LO outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_W;
            zero_r   <= 1'b1;
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
            acc_hi_r <= ZERO_W;
            acc_lo_r <= ZERO_W;
            b_r      <= ZERO_W;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (md_s) begin
                            acc_hi_r <= ZERO_W;
                            acc_lo_r <= opa_s;
                            b_r      <= opb_s;
                            is_div_r <= div_s;
                            neg_q_r  <= neg_q_s;
                            neg_r_r  <= neg_r_s;
                            cnt_r    <= CNT_INIT;
                            busy_r   <= 1'b1;
                            state_r  <= CALC;
                        end else begin
                            result_r <= alu_s;
                            zero_r   <= (alu_s == ZERO_W);
                            done_r   <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r - CNT_LAST;
                    if (cnt_r == CNT_LAST) begin
                        hi_r     <= fin_hi_s;
                        lo_r     <= fin_lo_s;
                        result_r <= fin_lo_s;
                        zero_r   <= (fin_lo_s == ZERO_W);
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= CALC;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign zero   = zero_r;
    assign hi     = hi_r;
    assign lo     = lo_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, multi-cycle sequences, randomized ops.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .result(result), .zero(zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a - b;
            4'd4: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd5: return (a < b) ? 32'd1 : 32'd0;
            4'd6: return a ^ b;
            4'd7: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] eh, output logic [W-1:0] el);
        logic [63:0] p;
        int q, r;
        eh = 32'd0;
        el = 32'd0;
        if (o == 4'd8) begin
            p = {32'd0, a} * {32'd0, b};
            {eh, el} = p;
        end else if (o == 4'd9) begin
            if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
            else begin el = a / b; eh = a % b; end
        end else if (o == 4'd10) begin
            p = longint'(int'(a)) * longint'(int'(b));
            {eh, el} = p;
        end else begin
            if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = 32'd0; end
            else begin
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                el = q;
                eh = r;
            end
        end
    endtask

    task automatic start_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_md(input logic poke, input logic [W-1:0] ph, input logic [W-1:0] pl,
                           output int n, output int nb);
        n = 0; nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (n == 10) begin
                chk("hold_hi_mid_op", hi, ph);
                chk("hold_lo_mid_op", lo, pl);
            end
            if (poke && n == 5) begin
                start = 1'b1; op = 4'd2; src_a = 32'd1; src_b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_md(input string nm, input logic [3:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic poke);
        logic [W-1:0] eh, el;
        int n, nb;
        md_ref(o, a, b, eh, el);
        start_op(o, a, b);
        chk({nm, "_busy_start"}, busy, 1'b1);
        wait_md(poke, hi, lo, n, nb);
        chk({nm, "_latency"}, n, W);
        chk({nm, "_busy_cycles"}, nb, W);
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_result"}, result, el);
        chk({nm, "_zero"}, zero, (el == 32'd0));
    endtask

    task automatic check_single(input string nm, input logic [3:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] er, input logic ez);
        logic [W-1:0] ph, pl;
        ph = hi; pl = lo;
        start_op(o, a, b);
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_result"}, result, er);
        chk({nm, "_zero"}, zero, ez);
        @(posedge clk); #1;
        chk({nm, "_done_drop"}, done, 1'b0);
        chk({nm, "_result_hold"}, result, er);
        chk({nm, "_hilo_hold"}, {hi, lo}, {ph, pl});
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[1]  = '{4'd3,  32'd5,         32'd5,         32'h0000_0000, 1'b1};
        vecs[2]  = '{4'd4,  32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0};
        vecs[3]  = '{4'd5,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1};
        vecs[4]  = '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[5]  = '{4'd1,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0};
        vecs[6]  = '{4'd6,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        vecs[7]  = '{4'd7,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{4'd3,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{4'd4,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[10] = '{4'd5,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[11] = '{4'd12, 32'd5,         32'd6,         32'h0000_0000, 1'b1};
        vecs[12] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

        reset = 1'b1; start = 1'b0; op = 4'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_done", done, 1'b0);

        for (int i = 0; i < 13; i++) begin
            check_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z);
        end

        check_md("multu_max", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("multu_hi_const", hi, 32'hFFFF_FFFE);
        chk("multu_lo_const", lo, 32'h0000_0001);
        @(posedge clk); #1;
        chk("multu_done_drop", done, 1'b0);
        check_single("add_after_mul", 4'd2, 32'd1, 32'd2, 32'd3, 1'b0);

        check_md("divu_100_7", 4'd9, 32'd100, 32'd7, 1'b0);
        chk("divu_lo_const", lo, 32'd14);
        chk("divu_hi_const", hi, 32'd2);
        check_md("divu_b2b_9_0", 4'd9, 32'd9, 32'd0, 1'b0);
        chk("divz_lo_const", lo, 32'hFFFF_FFFF);
        chk("divz_hi_const", hi, 32'd9);
        @(posedge clk); #1;
        chk("divu_done_drop", done, 1'b0);

        start_op(4'd8, 32'd12345, 32'd678);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_zero", zero, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_single("add_3_4", 4'd2, 32'd3, 32'd4, 32'd7, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_no_done", done, 1'b0);
        chk("post_rst_hilo", {hi, lo}, 64'd0);

`ifdef SEQ_ALU_SIGNED_MD_EN
        check_md("mult_m3_5", 4'd10, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo, 32'hFFFF_FFF1);
        check_md("div_m7_2", 4'd11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_hi_const", hi, 32'hFFFF_FFFF);
        check_md("div_m8_0", 4'd11, 32'hFFFF_FFF8, 32'd0, 1'b0);
        check_md("div_minneg_m1", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_minneg_lo", lo, 32'h8000_0000);
`else
        check_md("multu_seed", 4'd8, 32'd6, 32'd7, 1'b0);
        check_single("op10_reserved", 4'd10, 32'd6, 32'd7, 32'd0, 1'b1);
        check_single("op11_reserved", 4'd11, 32'd9, 32'd3, 32'd0, 1'b1);
        chk("reserved_lo_kept", lo, 32'd42);
`endif

        for (int i = 0; i < 20; i++) begin
            logic [3:0] o;
            logic [W-1:0] a, b, er;
            o = 4'($urandom_range(0, 11));
            if (o > 4'd7) o = o + 4'd4;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            er = ref_alu(o, a, b);
            check_single($sformatf("rnd_single%0d", i), o, a, b, er, (er == 32'd0));
        end

        for (int i = 0; i < 6; i++) begin
            logic [3:0] o;
            logic [W-1:0] a, b;
`ifdef SEQ_ALU_SIGNED_MD_EN
            o = 4'($urandom_range(8, 11));
`else
            o = 4'($urandom_range(8, 9));
`endif
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            check_md($sformatf("rnd_md%0d", i), o, a, b, (i == 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
